ps2_dev_tx: RTL and testbench

PS2_DEV_TX -- requirements
Module: ps2_dev_tx

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_tx_fifo.sv | 90 +++++++++
 rtl/ps2_dev_tx.sv | 159 +++++++++++++++
 tb/tb_ps2_dev_tx.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device transmitter.
// Used by both the PS2_DEV_TX_FIFO_EN and the single-register builds.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_GAP
   } ps2_state_e;

   localparam int         PS2_FRAME_BITS = 11;
   localparam logic [3:0] PS2_STOP_IDX   = 4'd10;
   localparam int         PS2_FIFO_DEPTH = 4;

   function automatic logic odd_par(input logic [7:0] d);
      return ~^d;
   endfunction

   // Bit i of the result is the i-th bit on the wire.
   function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(
      input logic [7:0] d
   );
      return {1'b1, odd_par(d), d, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte buffer between the accept port and the PS/2 framer.
// PS2_DEV_TX_FIFO_EN selects a 4-entry FIFO, else one holding register.
module ps2_tx_fifo
   import ps2_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic [7:0] dat_i,
   input  logic       pop_i,
   output logic [7:0] dat_o,
   output logic       empty_o,
   output logic       full_o
);

`ifdef PS2_DEV_TX_FIFO_EN

   localparam int AW = $clog2(PS2_FIFO_DEPTH);

   logic [7:0]    mem [PS2_FIFO_DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          push_ok;
   logic          pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(PS2_FIFO_DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   assign dat_o   = mem[rd_q];

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem[wr_q] <= dat_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) begin
            wr_q <= wr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_q <= rd_q + AW'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

`else

   logic [7:0] hold_q;
   logic       occ_q;
   logic       push_ok;
   logic       pop_ok;

   assign empty_o = !occ_q;
   assign full_o  = occ_q;
   assign pop_ok  = pop_i && occ_q;
   assign push_ok = push_i && (!occ_q || pop_ok);
   assign dat_o   = hold_q;

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         hold_q <= dat_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_q <= 1'b0;
      end else if (push_ok) begin
         occ_q <= 1'b1;
      end else if (pop_ok) begin
         occ_q <= 1'b0;
      end
   end

`endif

endmodule

// File: rtl/ps2_dev_tx.sv
// PS/2 device-to-host transmitter: buffered bytes, 11-bit frames, host inhibit abort.
// Buffer depth set by PS2_DEV_TX_FIFO_EN (see ps2_tx_fifo).
module ps2_dev_tx
   import ps2_pkg::*;
#(
   parameter int CLK_HALF = 2000,
   parameter int GAP_HALF = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] dat_i,
   input  logic       valid_i,
   output logic       ready_o,
   input  logic       inhibit_i,
   output logic       ps2_clk_o,
   output logic       ps2_dat_o,
   output logic       busy_o,
   output logic       abort_o
);

   localparam int CW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
   localparam int GW = (GAP_HALF > 1) ? $clog2(GAP_HALF) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HALF - 1);
   localparam logic [GW-1:0] GAP_MAX = GW'(GAP_HALF - 1);

   ps2_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [3:0]    bit_q, bit_d;
   logic [3:0]    bit_nxt;
   logic          clk_q, clk_d;
   logic          dat_q, dat_d;
   logic          abort_q, abort_d;
   logic          half_done;
   logic          do_abort;
   logic          pop;
   logic          push;
   logic          empty;
   logic          full;
   logic [7:0]    head;
   logic [PS2_FRAME_BITS-1:0] frame;

   ps2_tx_fifo u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .dat_i   (dat_i),
      .pop_i   (pop),
      .dat_o   (head),
      .empty_o (empty),
      .full_o  (full)
   );

   // A pop frees the slot in the same cycle, so a full buffer can still take a byte.
   assign ready_o   = !full || pop;
   assign push      = valid_i && ready_o;
   assign frame     = ps2_frame(head);
   assign half_done = (cnt_q == CNT_MAX);
   assign bit_nxt   = bit_q + 4'd1;
   assign do_abort  = inhibit_i && (bit_q < PS2_STOP_IDX);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      gap_d   = gap_q;
      bit_d   = bit_q;
      clk_d   = clk_q;
      dat_d   = dat_q;
      abort_d = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            gap_d = '0;
            bit_d = '0;
            clk_d = 1'b1;
            dat_d = 1'b1;
            if (!empty && !inhibit_i) begin
               state_d = ST_HIGH;
               dat_d   = frame[0];
            end
         end
         ST_HIGH: begin
            if (do_abort) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               bit_d   = '0;
               clk_d   = 1'b1;
               dat_d   = 1'b1;
               abort_d = 1'b1;
            end else if (half_done) begin
               state_d = ST_LOW;
               cnt_d   = '0;
               clk_d   = 1'b0;
            end
         end
         ST_LOW: begin
            if (do_abort) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               bit_d   = '0;
               clk_d   = 1'b1;
               dat_d   = 1'b1;
               abort_d = 1'b1;
            end else if (half_done) begin
               cnt_d = '0;
               clk_d = 1'b1;
               if (bit_q == PS2_STOP_IDX) begin
                  // Byte leaves the buffer only once the stop bit is fully out.
                  state_d = ST_GAP;
                  dat_d   = 1'b1;
                  pop     = 1'b1;
               end else begin
                  state_d = ST_HIGH;
                  bit_d   = bit_nxt;
                  dat_d   = frame[bit_nxt];
               end
            end
         end
         ST_GAP: begin
            if (half_done) begin
               cnt_d = '0;
               if (gap_q == GAP_MAX) begin
                  state_d = ST_IDLE;
                  gap_d   = '0;
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
         bit_q   <= '0;
         clk_q   <= 1'b1;
         dat_q   <= 1'b1;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         bit_q   <= bit_d;
         clk_q   <= clk_d;
         dat_q   <= dat_d;
         abort_q <= abort_d;
      end
   end

   assign ps2_clk_o = clk_q;
   assign ps2_dat_o = dat_q;
   assign abort_o   = abort_q;
   assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Scoreboard bench for ps2_dev_tx: accepted bytes queue expected frames,
// a wire monitor decodes PS/2 frames and checks timing. Honours PS2_DEV_TX_FIFO_EN.
module tb_ps2_dev_tx;

   localparam int CLK_HALF = 4;
   localparam int GAP_HALF = 2;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic [7:0] dat_i = '0;
   logic       valid_i = 1'b0;
   logic       inhibit_i = 1'b0;
   logic       ready_o;
   logic       ps2_clk_o;
   logic       ps2_dat_o;
   logic       busy_o;
   logic       abort_o;

   int total = 0;
   int bad = 0;

   logic [7:0] exp_q[$];

   int   nbits = 0;
   int   frames = 0;
   int   falls = 0;
   int   aborts = 0;
   int   run = 1;
   int   age = 1;
   int   gap_cnt = 0;
   bit   gap_on = 0;
   logic prev_clk = 1'b1;
   logic prev_dat = 1'b1;
   logic [10:0] cap = '0;

   ps2_dev_tx #(
      .CLK_HALF (CLK_HALF),
      .GAP_HALF (GAP_HALF)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .dat_i     (dat_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .inhibit_i (inhibit_i),
      .ps2_clk_o (ps2_clk_o),
      .ps2_dat_o (ps2_dat_o),
      .busy_o    (busy_o),
      .abort_o   (abort_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endtask

   // Wire frame derived from the protocol rules: start, LSB-first data, odd parity, stop.
   function automatic logic [10:0] model(input logic [7:0] b);
      logic [10:0] f;
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) ones++;
      end
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = b[i];
      end
      f[9]  = (ones % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   always @(negedge clk) begin
      if (rst_i) begin
         nbits = 0;
         gap_on = 0;
         run = 1;
         age = 1;
         prev_clk = ps2_clk_o;
         prev_dat = ps2_dat_o;
      end else begin
         if (gap_on) begin
            if (busy_o) gap_cnt++;
            else begin
               check("gap_len", gap_cnt, GAP_HALF * CLK_HALF);
               gap_on = 0;
            end
         end
         if (abort_o) begin
            aborts++;
            check("abort_clk", ps2_clk_o, 1);
            check("abort_dat", ps2_dat_o, 1);
            nbits = 0;
            run = 1;
         end else if (ps2_clk_o != prev_clk) begin
            if (!ps2_clk_o) begin
               falls++;
               if (nbits == 0) check("start_setup", age, CLK_HALF);
               else check("high_len", run, CLK_HALF);
               if (nbits < 11) cap[nbits] = ps2_dat_o;
               nbits++;
               if (nbits == 11) begin
                  frames++;
                  check("frame_expected", int'(exp_q.size() > 0), 1);
                  if (exp_q.size() > 0) begin
                     check("frame", int'(cap), int'(model(exp_q.pop_front())));
                  end
               end
            end else begin
               check("low_len", run, CLK_HALF);
               if (nbits >= 11) begin
                  nbits = 0;
                  gap_on = 1;
                  gap_cnt = 1;
               end
            end
            run = 1;
         end else begin
            run++;
         end
         if (ps2_dat_o != prev_dat) age = 1;
         else age++;
         prev_clk = ps2_clk_o;
         prev_dat = ps2_dat_o;
      end
   end

   task automatic send(input logic [7:0] d, input bit lat);
      int t;
      t = 0;
      while (!ready_o && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("send_ready", ready_o, 1);
      if (ready_o) begin
         dat_i = d;
         valid_i = 1'b1;
         exp_q.push_back(d);
         @(negedge clk);
         valid_i = 1'b0;
         if (lat) begin
            check("lat_c1", ps2_dat_o, 1);
            @(negedge clk);
            check("lat_c2", ps2_dat_o, 0);
         end
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy_o || exp_q.size() != 0) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("idle_timeout", int'(t < 5000), 1);
      @(negedge clk);
   endtask

   task automatic wait_bits(input int n);
      int t;
      t = 0;
      while (nbits != n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("bits_timeout", int'(t < 3000), 1);
   endtask

   initial begin
      int a0, f0, fl;
      logic [7:0] b;
      logic [7:0] seq [4];

      repeat (3) @(negedge clk);
      check("rst_clk", ps2_clk_o, 1);
      check("rst_dat", ps2_dat_o, 1);
      check("rst_ready", ready_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_abort", abort_o, 0);
      rst_i = 1'b0;
      @(negedge clk);

      send(8'h1C, 1);
      wait_idle();
      send(8'hF0, 1);
      wait_idle();

      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         send(b, 1);
         wait_idle();
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      // Inhibit during bit 4: abort, then full retransmission.
      a0 = aborts;
      f0 = frames;
      send(8'h1C, 1);
      wait_bits(4);
      repeat (CLK_HALF + 1) @(negedge clk);
      inhibit_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      fl = falls;
      repeat (48) @(negedge clk);
      check("inh_busy", busy_o, 0);
      check("inh_quiet", falls, fl);
      check("inh_clk", ps2_clk_o, 1);
      inhibit_i = 1'b0;
      wait_idle();
      check("abort_once", aborts - a0, 1);
      check("resend_frames", frames - f0, 1);
      fl = falls;
      repeat (100) @(negedge clk);
      check("no_repeat", falls, fl);

      // Inhibit during stop-bit high phase is ignored.
      a0 = aborts;
      f0 = frames;
      send(8'hA5, 1);
      wait_bits(10);
      repeat (CLK_HALF + 1) @(negedge clk);
      inhibit_i = 1'b1;
      repeat (8) @(negedge clk);
      inhibit_i = 1'b0;
      wait_idle();
      check("stop_no_abort", aborts - a0, 0);
      check("stop_frames", frames - f0, 1);
      fl = falls;
      repeat (100) @(negedge clk);
      check("stop_popped", falls, fl);

`ifdef PS2_DEV_TX_FIFO_EN
      seq[0] = 8'hE0;
      seq[1] = 8'hF0;
      seq[2] = 8'h74;
      seq[3] = 8'h11;
      f0 = frames;
      for (int i = 0; i < 4; i++) begin
         check("fifo_ready", ready_o, 1);
         dat_i = seq[i];
         valid_i = 1'b1;
         exp_q.push_back(seq[i]);
         @(negedge clk);
      end
      valid_i = 1'b0;
      check("fifo_full", ready_o, 0);
      dat_i = 8'h55;
      valid_i = 1'b1;
      repeat (10) @(negedge clk);
      valid_i = 1'b0;
      wait_idle();
      check("fifo_frames", frames - f0, 4);
`else
      seq[0] = 8'h3C;
      f0 = frames;
      send(seq[0], 1);
      check("hold_full", ready_o, 0);
      dat_i = 8'h55;
      valid_i = 1'b1;
      repeat (10) @(negedge clk);
      valid_i = 1'b0;
      begin
         int t;
         t = 0;
         while (!ready_o && t < 3000) begin
            @(negedge clk);
            t++;
         end
      end
      check("hold_release", frames - f0, 1);
      wait_idle();
      check("hold_frames", frames - f0, 1);
`endif

      // Reset mid-frame during bit 6.
      send(8'($urandom), 1);
      wait_bits(6);
      repeat (CLK_HALF + 1) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      check("mid_rst_clk", ps2_clk_o, 1);
      check("mid_rst_dat", ps2_dat_o, 1);
      check("mid_rst_ready", ready_o, 1);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_abort", abort_o, 0);
      exp_q.delete();
      rst_i = 1'b0;
      a0 = aborts;
      fl = falls;
      repeat (200) @(negedge clk);
      check("post_rst_quiet", falls, fl);
      check("post_rst_abort", aborts, a0);
      check("post_rst_busy", busy_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
